vr_log_ingest: RTL and testbench

- Log-write stage directly downstream of the prepare engine's `start_req_ingest` strobe.
- Captures the slot index, op number and request length for one PREPARE.
- Writes one header beat, then streams the request data-bus beats into the log RAM slot for that index.
- Raises `log_write_done` as a level. The prepare engine samples it before committing VR state.

---
 rtl/vr_log_ingest.sv | 156 +++++++++++++++
 tb/tb_vr_log_ingest.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vr_log_ingest.sv
// Log-write stage: records one PREPARE's header and request data beats into the
// log RAM slot selected by the start index, then holds log_write_done as a level.
module vr_log_ingest #(
    parameter int DATA_W          = 512,
    parameter int LOG_IDX_W       = 8,
    parameter int SLOT_BEATS_LOG2 = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_req_ingest,
    input  logic [LOG_IDX_W-1:0]                 start_log_idx,
    input  logic [63:0]                          start_op_num,
    input  logic [15:0]                          start_req_len,
    input  logic                                 req_data_val,
    input  logic [DATA_W-1:0]                    req_data,
    input  logic                                 req_data_last,
    output logic                                 ingest_req_data_rdy,
    output logic                                 log_wr_val,
    output logic [LOG_IDX_W+SLOT_BEATS_LOG2-1:0] log_wr_addr,
    output logic [DATA_W-1:0]                    log_wr_data,
    input  logic                                 log_wr_rdy,
    output logic                                 log_write_done,
    output logic                                 ingest_err,
    output logic                                 ingest_busy
);

    localparam logic [15:0] BEAT_BYTES = 16'(DATA_W / 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_HDR,
        S_DATA,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                       state_q, state_d;
    logic [LOG_IDX_W-1:0]         idx_q, idx_d;
    logic [63:0]                  op_q, op_d;
    logic [15:0]                  len_q, len_d;
    logic [15:0]                  exp_q, exp_d;
    logic [SLOT_BEATS_LOG2-1:0]   ptr_q, ptr_d;
    logic [15:0]                  rcv_q, rcv_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;
    logic [15:0]                  start_exp_beats;
    logic [DATA_W-1:0]            hdr_word;

    // Ceiling divide without a 16-bit add that could wrap near 64 KiB lengths.
    assign start_exp_beats = (start_req_len / BEAT_BYTES)
                           + 16'((start_req_len % BEAT_BYTES) != 16'd0);

    always_comb begin
        hdr_word = '0;
        hdr_word[DATA_W-1 -: 96] = {op_q, len_q, exp_q};
    end

    always_comb begin
        state_d             = state_q;
        idx_d               = idx_q;
        op_d                = op_q;
        len_d               = len_q;
        exp_d               = exp_q;
        ptr_d               = ptr_q;
        rcv_d               = rcv_q;
        done_d              = done_q;
        err_d               = err_q;
        log_wr_val          = 1'b0;
        log_wr_addr         = {idx_q, ptr_q};
        log_wr_data         = '0;
        ingest_req_data_rdy = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_req_ingest) begin
                    idx_d   = start_log_idx;
                    op_d    = start_op_num;
                    len_d   = start_req_len;
                    exp_d   = start_exp_beats;
                    ptr_d   = '0;
                    rcv_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_WR_HDR;
                end
            end
            S_WR_HDR: begin
                log_wr_val  = 1'b1;
                log_wr_addr = {idx_q, {SLOT_BEATS_LOG2{1'b0}}};
                log_wr_data = hdr_word;
                if (log_wr_rdy) begin
                    ptr_d   = SLOT_BEATS_LOG2'(1);
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                log_wr_val          = req_data_val;
                log_wr_data         = req_data;
                ingest_req_data_rdy = log_wr_rdy;
                if (req_data_val && log_wr_rdy) begin
                    ptr_d = ptr_q + SLOT_BEATS_LOG2'(1);
                    rcv_d = rcv_q + 16'd1;
                    if (req_data_last) begin
                        state_d = S_DONE;
                    end else if (ptr_q == '1) begin
                        // Slot full: this beat lands in the last word, the rest is dropped.
                        err_d   = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                ingest_req_data_rdy = 1'b1;
                if (req_data_val) begin
                    rcv_d = rcv_q + 16'd1;
                    if (req_data_last) state_d = S_DONE;
                end
            end
            S_DONE: begin
                err_d   = err_q | (rcv_q != exp_q);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            len_q   <= '0;
            exp_q   <= '0;
            ptr_q   <= '0;
            rcv_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            len_q   <= len_d;
            exp_q   <= exp_d;
            ptr_q   <= ptr_d;
            rcv_q   <= rcv_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign log_write_done = done_q;
    assign ingest_err     = err_q;
    assign ingest_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_vr_log_ingest.sv
// Scoreboard bench for vr_log_ingest: a slot-level reference model queues the
// expected RAM writes and completion status; a monitor checks what the DUT emits.
module tb_vr_log_ingest;

    localparam int DATA_W = 512;
    localparam int AW     = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_req_ingest;
    logic [7:0]        start_log_idx;
    logic [63:0]       start_op_num;
    logic [15:0]       start_req_len;
    logic              req_data_val;
    logic [DATA_W-1:0] req_data;
    logic              req_data_last;
    logic              ingest_req_data_rdy;
    logic              log_wr_val;
    logic [AW-1:0]     log_wr_addr;
    logic [DATA_W-1:0] log_wr_data;
    logic              log_wr_rdy;
    logic              log_write_done;
    logic              ingest_err;
    logic              ingest_busy;

    vr_log_ingest #(.DATA_W(DATA_W), .LOG_IDX_W(8), .SLOT_BEATS_LOG2(4)) dut (
        .clk(clk), .rst(rst),
        .start_req_ingest(start_req_ingest), .start_log_idx(start_log_idx),
        .start_op_num(start_op_num), .start_req_len(start_req_len),
        .req_data_val(req_data_val), .req_data(req_data), .req_data_last(req_data_last),
        .ingest_req_data_rdy(ingest_req_data_rdy),
        .log_wr_val(log_wr_val), .log_wr_addr(log_wr_addr), .log_wr_data(log_wr_data),
        .log_wr_rdy(log_wr_rdy), .log_write_done(log_write_done),
        .ingest_err(ingest_err), .ingest_busy(ingest_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               wr_q[$];
    bit                err_q[$];
    logic [DATA_W-1:0] beat_buf[$];
    int                errors   = 0;
    int                checks   = 0;
    int                cyc      = 0;
    int                rdy_mode = 0;   // 0: always ready, 1: toggle, 2: random
    bit                done_prev = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_word();
        logic [DATA_W-1:0] w;
        for (int unsigned i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       log_wr_rdy = 1'b1;
                1:       log_wr_rdy = ~log_wr_rdy;
                default: log_wr_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every presented write must match the head of the queue (also while stalled).
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (log_wr_val) begin
                    if (wr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr %0h expected no write", log_wr_addr);
                    end else begin
                        chk("wr_addr", DATA_W'(log_wr_addr), DATA_W'(wr_q[0].addr));
                        chk("wr_data", log_wr_data, wr_q[0].data);
                        if (log_wr_rdy) void'(wr_q.pop_front());
                    end
                end
                if (log_write_done && !done_prev) begin
                    if (err_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 expected none pending");
                    end else begin
                        chk("done_err", DATA_W'(ingest_err), DATA_W'(err_q.pop_front()));
                    end
                end
            end
            done_prev = log_write_done;
        end
    end

    // Reference model: a slot is header + up to 15 data words; extra beats are lost.
    task automatic model(input logic [7:0] idx, input logic [63:0] op, input logic [15:0] len,
                         input int n, input bit expect_done);
        int  exp_beats;
        wr_t w;
        exp_beats = (int'(len) + DATA_W / 8 - 1) / (DATA_W / 8);
        w.addr = {idx, 4'h0};
        w.data = '0;
        w.data[DATA_W-1 -: 96] = {op, len, 16'(exp_beats)};
        wr_q.push_back(w);
        for (int i = 0; i < n && i < 15; i++) begin
            w.addr = {idx, 4'(i + 1)};
            w.data = beat_buf[i];
            wr_q.push_back(w);
        end
        if (expect_done) err_q.push_back((n > 15) || (n != exp_beats));
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input bit last);
        int cnt = 0;
        bit acc = 1'b0;
        req_data_val  = 1'b1;
        req_data      = d;
        req_data_last = last;
        while (!acc && cnt < 200) begin
            @(negedge clk);
            acc = ingest_req_data_rdy;
            @(posedge clk);
            #1;
            start_req_ingest = 1'b0;
            cnt++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: got no accept expected accept within 200 cycles");
        end
        req_data_val  = 1'b0;
        req_data_last = 1'b0;
    endtask

    task automatic start(input logic [7:0] idx, input logic [63:0] op, input logic [15:0] len,
                         output int cap);
        start_req_ingest = 1'b1;
        start_log_idx    = idx;
        start_op_num     = op;
        start_req_len    = len;
        @(posedge clk);
        #1;
        start_req_ingest = 1'b0;
        cap = cyc;
        @(negedge clk);
        chk("capture_done_clr", DATA_W'(log_write_done), '0);
        chk("capture_err_clr", DATA_W'(ingest_err), '0);
        chk("capture_busy", DATA_W'(ingest_busy), DATA_W'(1));
    endtask

    task automatic ingest(input logic [7:0] idx, input logic [63:0] op, input logic [15:0] len,
                          input int n, input bit gaps, input bit glitch, input bit lat);
        int cap;
        int w;
        beat_buf.delete();
        for (int i = 0; i < n; i++) beat_buf.push_back(rnd_word());
        model(idx, op, len, n, 1'b1);
        start(idx, op, len, cap);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if (glitch && i == 1) begin
                start_req_ingest = 1'b1;
                start_log_idx    = ~idx;
                start_op_num     = ~op;
                start_req_len    = ~len;
            end
            send_beat(beat_buf[i], i == n - 1);
        end
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!log_write_done && w < 40);
        if (!log_write_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=0 expected done=1 within 40 cycles");
        end
        if (lat) chk("done_latency", DATA_W'(cyc - cap), DATA_W'(3));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish by 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        int cap;
        logic [7:0]  idx;
        logic [15:0] len;
        int          n;
        rst = 1'b1;
        start_req_ingest = 1'b0;
        start_log_idx = '0;
        start_op_num = '0;
        start_req_len = '0;
        req_data_val = 1'b0;
        req_data = '0;
        req_data_last = 1'b0;
        log_wr_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_done", DATA_W'(log_write_done), '0);
        chk("rst_err", DATA_W'(ingest_err), '0);
        chk("rst_busy", DATA_W'(ingest_busy), '0);
        chk("rst_wr_val", DATA_W'(log_wr_val), '0);
        chk("rst_data_rdy", DATA_W'(ingest_req_data_rdy), '0);
        @(posedge clk);
        #1;

        rdy_mode = 0;
        ingest(8'd5, 64'h1234, 16'd64, 1, 1'b0, 1'b0, 1'b1);
        chk("idle_done_level", DATA_W'(log_write_done), DATA_W'(1));
        rdy_mode = 1;
        ingest(8'h21, {$urandom, $urandom}, 16'd200, 4, 1'b0, 1'b0, 1'b0);
        rdy_mode = 0;
        ingest(8'd3, 64'hdead_beef, 16'd128, 1, 1'b0, 1'b0, 1'b0);
        ingest(8'hff, 64'h55, 16'd1280, 20, 1'b0, 1'b0, 1'b0);
        ingest(8'd9, 64'h99, 16'd192, 3, 1'b0, 1'b1, 1'b0);
        ingest(8'd10, 64'h1010, 16'd64, 1, 1'b0, 1'b0, 1'b0);
        ingest(8'd0, 64'h0, 16'd0, 1, 1'b0, 1'b0, 1'b0);

        // Reset while streaming: header and two beats land, then the ingest is abandoned.
        beat_buf.delete();
        for (int i = 0; i < 2; i++) beat_buf.push_back(rnd_word());
        model(8'd7, 64'h77, 16'd192, 2, 1'b0);
        start(8'd7, 64'h77, 16'd192, cap);
        send_beat(beat_buf[0], 1'b0);
        send_beat(beat_buf[1], 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", DATA_W'(ingest_busy), '0);
        chk("midrst_done", DATA_W'(log_write_done), '0);
        chk("midrst_err", DATA_W'(ingest_err), '0);
        chk("midrst_wr_val", DATA_W'(log_wr_val), '0);
        @(posedge clk);
        #1;
        ingest(8'd7, 64'h78, 16'd100, 2, 1'b0, 1'b0, 1'b0);

        rdy_mode = 2;
        for (int t = 0; t < 25; t++) begin
            idx = 8'($urandom);
            n   = $urandom_range(1, 18);
            if ($urandom_range(0, 3) == 0) len = 16'($urandom_range(0, 1300));
            else                           len = 16'(n * 64 - $urandom_range(0, 63));
            ingest(idx, {$urandom, $urandom}, len, n, 1'b1, 1'b0, 1'b0);
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("writes_drained", DATA_W'(wr_q.size()), '0);
        chk("dones_drained", DATA_W'(err_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
